nand_page_seq: RTL and testbench
================================

NAND_PAGE_SEQ -- requirements
Module: nand_page_seq

Interface
REQ-001 SHALL have parameter CE_NUM, default 2: number of NAND chip enables, range 1..4.
REQ-002 SHALL have parameter ROW_W, default 16: row address width, range 8..16.
REQ-003 SHALL have parameter MUTE_CYC, default 20: guard cycles after each busy phase, minimum 1.
REQ-004 SHALL have parameter BUSY_TO, default 65535: maximum cycles allowed per busy-wait state.
REQ-005 SHALL have parameter RST_ON_START, default 1: 1 means every START issues a chip reset; 0 means only the first START after RST issues one.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 CLK  in  1  system clock.
REQ-008 RST  in  1  synchronous active-high reset.
REQ-009 START  in  1  request a page read; sampled only in IDLE.
REQ-010 ABORT  in  1  cancel the operation in progress.
REQ-011 ADDR_NAND  in  ROW_W  page row address.
REQ-012 CE_IDX  in  2  target chip index, valid values 0..CE_NUM-1.
REQ-013 RB  in  1  NAND ready/busy; 0 = busy.
REQ-014 CW_ENA  out  1  command-writer enable.
REQ-015 CW_CMD  out  56  command/address word for the command writer.
REQ-016 CW_DONE  in  1  command-writer complete.
REQ-017 DR_ENA  out  1  data-reader enable.
REQ-018 DR_DONE  in  1  data-reader complete.
REQ-019 CE_N  out  CE_NUM  active-low chip enables.
REQ-020 BUSY  out  1  high whenever the FSM is not in IDLE.
REQ-021 COMPLT  out  1  one-cycle pulse on successful finish.
REQ-022 ERR  out  1  sticky error flag.
REQ-023 ERR_CODE  out  2  error cause: 01 = reset busy timeout, 10 = read busy timeout, 11 = bad CE_IDX.

Function
REQ-024 SHALL implement states IDLE, SEND_RST, WAIT_RB_RST, MUTE_RST, SEND_READ, WAIT_RB_READ, MUTE_READ, READ_DATA, DONE, ERROR.
REQ-025 In IDLE, START=1 SHALL latch ADDR_NAND and CE_IDX, clear ERR and ERR_CODE, and move to the next state on the following cycle.
- CE_IDX >= CE_NUM: go to ERROR, code 11.
- Otherwise, if the chip-reset-needed flag is set or RST_ON_START=1: go to SEND_RST.
- Otherwise: go to SEND_READ.
REQ-026 The chip-reset-needed flag SHALL be set by RST and cleared on entry to MUTE_RST.
REQ-027 In SEND_RST and SEND_READ, CW_ENA SHALL assert only while CW_DONE=0; once CW_DONE=1 is sampled, CW_ENA SHALL drop in the next cycle and the FSM SHALL advance to the matching WAIT_RB state.
REQ-028 CW_CMD SHALL be driven as follows:
- SEND_RST: 56'hFF_00_00_00_00_00_00.
- SEND_READ: [55:32]=0; [31:16] = latched address, zero-extended to 16 bits, MSB at bit 31 side; [15:0]=16'h0030.
REQ-029 Each WAIT_RB state SHALL first require RB=0 and then RB=1 before moving to the matching MUTE state; a cycle counter cleared on state entry SHALL force ERROR when it reaches BUSY_TO (code 01 for reset, 10 for read).
REQ-030 Each MUTE state SHALL last exactly MUTE_CYC cycles, then go to SEND_READ (after MUTE_RST) or READ_DATA (after MUTE_READ).
REQ-031 READ_DATA SHALL hold DR_ENA=1 until DR_DONE=1 is sampled, then go to DONE with DR_ENA=0.
REQ-032 DONE SHALL pulse COMPLT for one cycle and return to IDLE.
REQ-033 ERROR SHALL drop all enables, hold ERR=1, and return to IDLE after one cycle; ERR and ERR_CODE SHALL hold until the next accepted START or RST.
REQ-034 CE_N[latched index] SHALL be 0 from SEND_RST/SEND_READ through READ_DATA inclusive; all other CE_N bits SHALL stay 1 in every state.
REQ-035 ABORT=1 in any non-IDLE state SHALL return the FSM to IDLE on the next cycle with CW_ENA=0, DR_ENA=0, CE_N all 1, no COMPLT and no ERR; ABORT SHALL also set the chip-reset-needed flag.
REQ-036 If ABORT and START are both high in IDLE, START SHALL be ignored.

Reset
REQ-037 RST SHALL force state IDLE, the chip-reset-needed flag to 1, and counters to 0.
REQ-038 RST SHALL drive outputs to: CW_ENA=0, CW_CMD=0, DR_ENA=0, CE_N all 1, BUSY=0, COMPLT=0, ERR=0, ERR_CODE=00.
REQ-039 RST asserted mid-operation SHALL take priority over all other inputs.

Verification
REQ-040 Nominal read: RST, then START with ADDR=16'h1234, CE_IDX=1 -> CW_CMD=FF.., RB low/high, 20 mute cycles, CW_CMD=56'h00_0000_1234_0030, DR handshake; COMPLT pulses once; CE_N=2'b01 throughout.
REQ-041 Reset skip: RST_ON_START=0, second START -> goes straight to SEND_READ; no FF command issued.
REQ-042 Busy timeout: BUSY_TO=100, RB held 1 after the read command -> ERR=1, ERR_CODE=10 after 100 cycles; CE_N all 1.
REQ-043 Bad chip index: CE_NUM=2, START with CE_IDX=3 -> ERR_CODE=11; no CW_ENA ever asserted.
REQ-044 Abort: ABORT during READ_DATA -> IDLE next cycle, DR_ENA=0, no COMPLT; next START issues FF reset.
REQ-045 Reset mid-op: RST asserted in WAIT_RB_READ -> all outputs take reset values on the next edge.

Source files
------------

// File: rtl/nand_page_seq.sv
// rtl/nand_page_seq.sv - NAND page-read sequencer: optional chip reset, read command,
// busy waits with timeout, guard delay, data fetch.
module nand_page_seq #(
   parameter int CE_NUM       = 2,
   parameter int ROW_W        = 16,
   parameter int MUTE_CYC     = 20,
   parameter int BUSY_TO      = 65535,
   parameter int RST_ON_START = 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   input  logic              ABORT,
   input  logic [ROW_W-1:0]  ADDR_NAND,
   input  logic [1:0]        CE_IDX,
   input  logic              RB,
   output logic              CW_ENA,
   output logic [55:0]       CW_CMD,
   input  logic              CW_DONE,
   output logic              DR_ENA,
   input  logic              DR_DONE,
   output logic [CE_NUM-1:0] CE_N,
   output logic              BUSY,
   output logic              COMPLT,
   output logic              ERR,
   output logic [1:0]        ERR_CODE
);

   typedef enum logic [3:0] {
      S_IDLE, S_SEND_RST, S_WAIT_RB_RST, S_MUTE_RST, S_SEND_READ,
      S_WAIT_RB_READ, S_MUTE_READ, S_READ_DATA, S_DONE, S_ERROR
   } state_t;

   localparam logic [31:0] BUSY_LIM = 32'(BUSY_TO);
   localparam logic [31:0] MUTE_LIM = 32'(MUTE_CYC);

   state_t           state_q, state_d;
   logic [ROW_W-1:0] addr_q, addr_d;
   logic [1:0]       ce_q, ce_d;
   logic             rst_needed_q, rst_needed_d;
   logic             seen_low_q, seen_low_d;
   logic [31:0]      cnt_q, cnt_d;
   logic             err_q, err_d;
   logic [1:0]       err_code_q, err_code_d;
   logic             bad_ce;
   logic             ce_active;
   logic [15:0]      addr16;

   assign bad_ce = ({30'd0, CE_IDX} >= 32'(CE_NUM));
   assign addr16 = 16'(addr_q);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         ce_q         <= '0;
         rst_needed_q <= 1'b1;
         seen_low_q   <= 1'b0;
         cnt_q        <= '0;
         err_q        <= 1'b0;
         err_code_q   <= 2'b00;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         ce_q         <= ce_d;
         rst_needed_q <= rst_needed_d;
         seen_low_q   <= seen_low_d;
         cnt_q        <= cnt_d;
         err_q        <= err_d;
         err_code_q   <= err_code_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      ce_d         = ce_q;
      rst_needed_d = rst_needed_q;
      err_d        = err_q;
      err_code_d   = err_code_q;
      if (state_q != S_IDLE && ABORT) begin
         state_d      = S_IDLE;
         rst_needed_d = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (START && !ABORT) begin
                  addr_d     = ADDR_NAND;
                  ce_d       = CE_IDX;
                  err_d      = 1'b0;
                  err_code_d = 2'b00;
                  if (bad_ce) begin
                     state_d    = S_ERROR;
                     err_d      = 1'b1;
                     err_code_d = 2'b11;
                  end else if (rst_needed_q || RST_ON_START != 0) begin
                     state_d = S_SEND_RST;
                  end else begin
                     state_d = S_SEND_READ;
                  end
               end
            end
            S_SEND_RST:  if (CW_DONE) state_d = S_WAIT_RB_RST;
            S_SEND_READ: if (CW_DONE) state_d = S_WAIT_RB_READ;
            S_WAIT_RB_RST: begin
               if (seen_low_q && RB) begin
                  state_d = S_MUTE_RST;
               end else if (cnt_q + 32'd1 >= BUSY_LIM) begin
                  state_d    = S_ERROR;
                  err_d      = 1'b1;
                  err_code_d = 2'b01;
               end
            end
            S_WAIT_RB_READ: begin
               if (seen_low_q && RB) begin
                  state_d = S_MUTE_READ;
               end else if (cnt_q + 32'd1 >= BUSY_LIM) begin
                  state_d    = S_ERROR;
                  err_d      = 1'b1;
                  err_code_d = 2'b10;
               end
            end
            S_MUTE_RST:  if (cnt_q + 32'd1 >= MUTE_LIM) state_d = S_SEND_READ;
            S_MUTE_READ: if (cnt_q + 32'd1 >= MUTE_LIM) state_d = S_READ_DATA;
            S_READ_DATA: if (DR_DONE) state_d = S_DONE;
            S_DONE:      state_d = S_IDLE;
            S_ERROR:     state_d = S_IDLE;
            default:     state_d = S_IDLE;
         endcase
      end
      if (state_d == S_MUTE_RST && state_q != S_MUTE_RST) rst_needed_d = 1'b0;
      // Busy/mute counter and RB-low tracker restart on every state change
      cnt_d      = (state_d != state_q) ? 32'd0 : cnt_q + 32'd1;
      seen_low_d = (state_d != state_q) ? 1'b0 : (seen_low_q | ~RB);
   end

   always_comb begin
      CW_ENA    = 1'b0;
      CW_CMD    = '0;
      DR_ENA    = 1'b0;
      BUSY      = (state_q != S_IDLE);
      COMPLT    = (state_q == S_DONE);
      ERR       = err_q;
      ERR_CODE  = err_code_q;
      ce_active = 1'b0;
      case (state_q)
         S_SEND_RST: begin
            CW_ENA = 1'b1;
            CW_CMD = 56'hFF00_0000_0000_00;
         end
         S_SEND_READ: begin
            CW_ENA = 1'b1;
            CW_CMD = {24'h000000, addr16, 16'h0030};
         end
         S_READ_DATA: DR_ENA = 1'b1;
         default: ;
      endcase
      case (state_q)
         S_SEND_RST, S_WAIT_RB_RST, S_MUTE_RST, S_SEND_READ,
         S_WAIT_RB_READ, S_MUTE_READ, S_READ_DATA: ce_active = 1'b1;
         default: ce_active = 1'b0;
      endcase
      CE_N = '1;
      for (int i = 0; i < CE_NUM; i++) begin
         if (ce_active && ce_q == 2'(i)) CE_N[i] = 1'b0;
      end
   end

endmodule

// File: tb/tb_nand_page_seq.sv
// tb/tb_nand_page_seq.sv - scoreboard bench for nand_page_seq (reset skip, timeout, bad index, abort, reset mid-op).
module tb_nand_page_seq;

   localparam int CE_NUM   = 2;
   localparam int ROW_W    = 16;
   localparam int MUTE_CYC = 20;
   localparam int BUSY_TO  = 100;
   localparam logic [55:0] CMD_RST = 56'hFF00_0000_0000_00;
   localparam logic [1:0]  K_CMD = 2'd0, K_DONE = 2'd1, K_ERR = 2'd2;

   typedef struct {
      logic [1:0]  kind;
      logic [55:0] data;
      logic [1:0]  ce_n;
   } exp_t;

   logic              CLK = 1'b0;
   logic              RST, START, ABORT, RB, CW_DONE, DR_DONE;
   logic [ROW_W-1:0]  ADDR_NAND;
   logic [1:0]        CE_IDX;
   logic              CW_ENA, DR_ENA, BUSY, COMPLT, ERR;
   logic [55:0]       CW_CMD;
   logic [CE_NUM-1:0] CE_N;
   logic [1:0]        ERR_CODE;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   logic cw_prev = 1'b0;

   nand_page_seq #(
      .CE_NUM(CE_NUM), .ROW_W(ROW_W), .MUTE_CYC(MUTE_CYC),
      .BUSY_TO(BUSY_TO), .RST_ON_START(0)
   ) dut (
      .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT),
      .ADDR_NAND(ADDR_NAND), .CE_IDX(CE_IDX), .RB(RB),
      .CW_ENA(CW_ENA), .CW_CMD(CW_CMD), .CW_DONE(CW_DONE),
      .DR_ENA(DR_ENA), .DR_DONE(DR_DONE), .CE_N(CE_N),
      .BUSY(BUSY), .COMPLT(COMPLT), .ERR(ERR), .ERR_CODE(ERR_CODE)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [1:0] k, input logic [55:0] d, input logic [1:0] ce);
      exp_q.push_back('{k, d, ce});
   endtask

   function automatic logic [55:0] rd_cmd(input logic [15:0] a);
      return {24'h000000, a, 16'h0030};
   endfunction

   task automatic wait_for(input int sel, input int bound, output int n);
      n = 0;
      while (n < bound && !((sel == 0 && CW_ENA === 1'b1) ||
                            (sel == 1 && DR_ENA === 1'b1) ||
                            (sel == 2 && ERR === 1'b1))) begin
         tick();
         n++;
      end
   endtask

   task automatic do_cmd(input string name);
      int n;
      wait_for(0, 10, n);
      check({name, "_cw_ena"}, 64'(CW_ENA), 64'd1);
      CW_DONE = 1'b1;
      tick();
      CW_DONE = 1'b0;
      check({name, "_cw_drop"}, 64'(CW_ENA), 64'd0);
   endtask

   task automatic busy_pulse();
      RB = 1'b0;
      tick();
      tick();
      RB = 1'b1;
   endtask

   task automatic run_read(input logic [15:0] a, input logic [1:0] idx, input bit with_rst,
                           input logic [55:0] rdc);
      logic [1:0] ce_exp;
      int n;
      ce_exp = (idx == 2'd0) ? 2'b10 : 2'b01;
      if (with_rst) push(K_CMD, CMD_RST, ce_exp);
      push(K_CMD, rdc, ce_exp);
      push(K_DONE, 56'd0, 2'b11);
      ADDR_NAND = a;
      CE_IDX    = idx;
      START     = 1'b1;
      tick();
      START = 1'b0;
      check("start_clears_err", 64'(ERR), 64'd0);
      check("busy_after_start", 64'(BUSY), 64'd1);
      if (with_rst) begin
         do_cmd("rst");
         busy_pulse();
         wait_for(0, 40, n);
         check("mute_rst_len", 64'(n), 64'd21);
      end
      do_cmd("read");
      busy_pulse();
      wait_for(1, 40, n);
      check("mute_read_len", 64'(n), 64'd21);
      check("ce_n_read_data", 64'(CE_N), 64'(ce_exp));
      tick();
      check("dr_ena_hold", 64'(DR_ENA), 64'd1);
      DR_DONE = 1'b1;
      tick();
      DR_DONE = 1'b0;
      check("dr_ena_drop", 64'(DR_ENA), 64'd0);
      check("complt_pulse", 64'(COMPLT), 64'd1);
      tick();
      check("complt_one_cycle", 64'(COMPLT), 64'd0);
      check("idle_after_done", 64'(BUSY), 64'd0);
   endtask

   task automatic pop_check(input logic [1:0] k, input logic [55:0] d, input string name);
      exp_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_%s: got event data %0h, expected no event", name, d);
      end else begin
         e = exp_q.pop_front();
         check({name, "_kind"}, 64'(k), 64'(e.kind));
         if (k != K_DONE) check({name, "_data"}, 64'(d), 64'(e.data));
         check({name, "_ce_n"}, 64'(CE_N), 64'(e.ce_n));
      end
   endtask

   always @(negedge CLK) begin
      if (RST === 1'b0) begin
         if (CW_ENA && !cw_prev) pop_check(K_CMD, CW_CMD, "cmd");
         if (COMPLT) pop_check(K_DONE, 56'd0, "complt");
         if (ERR && BUSY) pop_check(K_ERR, {54'd0, ERR_CODE}, "err");
      end
      cw_prev = CW_ENA;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      RST = 1'b1; START = 1'b0; ABORT = 1'b0; RB = 1'b1;
      CW_DONE = 1'b0; DR_DONE = 1'b0; ADDR_NAND = '0; CE_IDX = '0;
      repeat (3) tick();
      check("rst_cw_ena", 64'(CW_ENA), 64'd0);
      check("rst_cw_cmd", 64'(CW_CMD), 64'd0);
      check("rst_dr_ena", 64'(DR_ENA), 64'd0);
      check("rst_ce_n", 64'(CE_N), 64'd3);
      check("rst_busy", 64'(BUSY), 64'd0);
      check("rst_complt", 64'(COMPLT), 64'd0);
      check("rst_err", 64'(ERR), 64'd0);
      check("rst_err_code", 64'(ERR_CODE), 64'd0);
      RST = 1'b0;
      tick();

      // first START after reset always resets the chip
      run_read(16'h1234, 2'd1, 1'b1, 56'h00_0000_1234_0030);
      // reset skipped on the next START
      run_read(16'hABCD, 2'd0, 1'b0, 56'h00_0000_ABCD_0030);

      // read busy timeout: RB never goes low
      push(K_CMD, 56'h00_0000_0055_0030, 2'b01);
      push(K_ERR, 56'd2, 2'b11);
      ADDR_NAND = 16'h0055; CE_IDX = 2'd1; START = 1'b1;
      tick();
      START = 1'b0;
      do_cmd("to");
      wait_for(2, 200, n);
      check("busy_timeout_cycles", 64'(n), 64'd100);
      check("to_ce_n", 64'(CE_N), 64'd3);
      check("to_code", 64'(ERR_CODE), 64'd2);
      tick();
      check("to_err_sticky", 64'(ERR), 64'd1);
      check("to_idle", 64'(BUSY), 64'd0);

      // bad chip index
      push(K_ERR, 56'd3, 2'b11);
      CE_IDX = 2'd3; START = 1'b1;
      tick();
      START = 1'b0;
      check("badidx_code", 64'(ERR_CODE), 64'd3);
      check("badidx_cw_ena", 64'(CW_ENA), 64'd0);
      tick();
      check("badidx_idle", 64'(BUSY), 64'd0);
      check("badidx_err_sticky", 64'(ERR), 64'd1);

      // ABORT together with START in IDLE is ignored
      ABORT = 1'b1; START = 1'b1; CE_IDX = 2'd1;
      tick();
      ABORT = 1'b0; START = 1'b0;
      check("abort_start_ignored", 64'(BUSY), 64'd0);

      // abort during READ_DATA
      push(K_CMD, 56'h00_0000_0F0F_0030, 2'b01);
      ADDR_NAND = 16'h0F0F; CE_IDX = 2'd1; START = 1'b1;
      tick();
      START = 1'b0;
      do_cmd("ab");
      busy_pulse();
      wait_for(1, 40, n);
      check("ab_dr_ena", 64'(DR_ENA), 64'd1);
      ABORT = 1'b1;
      tick();
      ABORT = 1'b0;
      check("abort_idle", 64'(BUSY), 64'd0);
      check("abort_dr_ena", 64'(DR_ENA), 64'd0);
      check("abort_ce_n", 64'(CE_N), 64'd3);
      check("abort_no_err", 64'(ERR), 64'd0);
      repeat (3) tick();
      run_read(16'h00C3, 2'd0, 1'b1, 56'h00_0000_00C3_0030);

      // RST while in WAIT_RB_READ
      push(K_CMD, 56'h00_0000_7777_0030, 2'b01);
      ADDR_NAND = 16'h7777; CE_IDX = 2'd1; START = 1'b1;
      tick();
      START = 1'b0;
      do_cmd("mid");
      RB = 1'b0;
      tick();
      RST = 1'b1;
      tick();
      check("mid_cw_ena", 64'(CW_ENA), 64'd0);
      check("mid_cw_cmd", 64'(CW_CMD), 64'd0);
      check("mid_dr_ena", 64'(DR_ENA), 64'd0);
      check("mid_ce_n", 64'(CE_N), 64'd3);
      check("mid_busy", 64'(BUSY), 64'd0);
      check("mid_complt", 64'(COMPLT), 64'd0);
      check("mid_err", 64'(ERR), 64'd0);
      check("mid_err_code", 64'(ERR_CODE), 64'd0);
      RST = 1'b0; RB = 1'b1;
      tick();
      run_read(16'hBEEF, 2'd1, 1'b1, 56'h00_0000_BEEF_0030);

      repeat (5) tick();
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
